// File: rtl/invaders_pkg.sv
// invaders_pkg
// Shared definitions for the invader formation: fleet FSM state type plus the
// formation size, sprite geometry and playfield limits. The same constants are
// used by color_mapper (sprite placement) and the bullet collision logic, so
// everything that has to agree on where an invader sits lives here.
package invaders_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CLEARED,
        LANDED
    } fleet_state_t;

    localparam int ROWS      = 5;
    localparam int COLS      = 8;
    localparam int ALIEN_W   = 16;
    localparam int ALIEN_H   = 16;
    localparam int SPACING_X = 24;
    localparam int SPACING_Y = 20;
    localparam int START_X   = 64;
    localparam int START_Y   = 48;
    localparam int STEP_X    = 4;
    localparam int STEP_Y    = 8;
    localparam int X_MIN     = 0;
    localparam int X_MAX     = 639;
    localparam int LAND_Y    = 439;

endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync
// Brings the VGA vertical sync into the Clk domain and turns each rising edge
// into a single-cycle tick.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   vs_i   : vertical sync, asynchronous to clk_i
//   tick_o : one-cycle pulse, high after the third clk_i edge following a
//            rising edge of vs_i
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic vs_i,
    output logic tick_o
);

    logic metaQ;
    logic syncQ;
    logic prevQ;
    logic tickQ;

    // Two flops of synchronisation, one flop of history for the edge detect,
    // and a registered tick so the consumer sees a clean, glitch-free pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            metaQ <= 1'b0;
            syncQ <= 1'b0;
            prevQ <= 1'b0;
            tickQ <= 1'b0;
        end else begin
            metaQ <= vs_i;
            syncQ <= metaQ;
            prevQ <= syncQ;
            tickQ <= syncQ & ~prevQ;
        end
    end

    assign tick_o = tickQ;

endmodule

// File: rtl/invader_fleet_ctrl.sv
// invader_fleet_ctrl
// Owns the invader formation: alive mask, fleet origin, march direction and
// pacing. Steps once per movement period (in video frames), descends and
// reverses at the playfield edges, speeds up as invaders die, and accepts kill
// reports from the collision logic.
//   Clk, Reset_n      : clock, asynchronous active-low reset
//   frame_vs          : VGA vsync (asynchronous), paces the march
//   start             : pulse, (re)starts a wave
//   hit_valid/row/col : collision report; hit_ack pulses when it killed
//   fleet_x, fleet_y  : formation origin (column 0 left / row 0 top)
//   alive_mask        : bit r*COLS+c = invader (r,c) alive; alive_count = popcount
//   dir_right, anim_frame, fleet_step : march direction, sprite pose, step pulse
//   fleet_cleared, fleet_landed, running : wave status levels
module invader_fleet_ctrl import invaders_pkg::*; #(
    parameter int ROWS      = invaders_pkg::ROWS,
    parameter int COLS      = invaders_pkg::COLS,
    parameter int ALIEN_W   = invaders_pkg::ALIEN_W,
    parameter int ALIEN_H   = invaders_pkg::ALIEN_H,
    parameter int SPACING_X = invaders_pkg::SPACING_X,
    parameter int SPACING_Y = invaders_pkg::SPACING_Y,
    parameter int START_X   = invaders_pkg::START_X,
    parameter int START_Y   = invaders_pkg::START_Y,
    parameter int STEP_X    = invaders_pkg::STEP_X,
    parameter int STEP_Y    = invaders_pkg::STEP_Y,
    parameter int X_MIN     = invaders_pkg::X_MIN,
    parameter int X_MAX     = invaders_pkg::X_MAX,
    parameter int LAND_Y    = invaders_pkg::LAND_Y
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_vs,
    input  logic                 start,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_row,
    input  logic [2:0]           hit_col,
    output logic                 hit_ack,
    output logic [9:0]           fleet_x,
    output logic [9:0]           fleet_y,
    output logic [ROWS*COLS-1:0] alive_mask,
    output logic [5:0]           alive_count,
    output logic                 dir_right,
    output logic                 anim_frame,
    output logic                 fleet_step,
    output logic                 fleet_cleared,
    output logic                 fleet_landed,
    output logic                 running
);

    localparam int NUM   = ROWS * COLS;
    localparam int IDX_W = $clog2(NUM);

    fleet_state_t   state_q, state_d;
    logic [9:0]     fleetX_q, fleetX_d;
    logic [9:0]     fleetY_q, fleetY_d;
    logic           dirRight_q, dirRight_d;
    logic [NUM-1:0] aliveMask_q, aliveMask_d;
    logic           animFrame_q, animFrame_d;
    logic [5:0]     frameCnt_q, frameCnt_d;
    logic           hitAck_q, hitAck_d;
    logic           fleetStep_q, fleetStep_d;

    logic            tick;
    logic [COLS-1:0] colOcc;
    logic [ROWS-1:0] rowOcc;
    logic [2:0]      lcol, rcol, brow;
    logic [5:0]      popCount;
    logic [5:0]      period;
    logic            hitOk;
    logic [IDX_W-1:0] hitIdx;
    logic [10:0]     rightEdge, leftEdge, bottomNext;
    logic            descend;
    logic [9:0]      yAfter;

    frame_tick_sync uTick (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .vs_i   (frame_vs),
        .tick_o (tick)
    );

    // Occupancy of the current (pre-hit) mask: which columns and rows still
    // hold anyone, the extreme live column/row, and the live-invader count.
    // Edge checks use the outermost live column, so a fleet with its outer
    // columns shot away marches further before reversing.
    always_comb begin
        colOcc   = '0;
        rowOcc   = '0;
        lcol     = '0;
        rcol     = '0;
        brow     = '0;
        popCount = '0;
        for (int r = 0; r < ROWS; r++) begin
            colOcc    = colOcc | aliveMask_q[r*COLS +: COLS];
            rowOcc[r] = |aliveMask_q[r*COLS +: COLS];
        end
        for (int c = COLS - 1; c >= 0; c--) begin
            if (colOcc[c]) lcol = 3'(c);
        end
        for (int c = 0; c < COLS; c++) begin
            if (colOcc[c]) rcol = 3'(c);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (rowOcc[r]) brow = 3'(r);
        end
        for (int i = 0; i < NUM; i++) begin
            popCount = popCount + 6'(aliveMask_q[i]);
        end
    end

    // Step geometry in 11 bits so a fleet pushed past the 10-bit screen range
    // compares as off-screen instead of wrapping back into view.
    always_comb begin
        period     = (popCount >> 2) + 6'd1;
        hitIdx     = IDX_W'(int'(hit_row) * COLS + int'(hit_col));
        hitOk      = hit_valid && (int'(hit_row) < ROWS) && (int'(hit_col) < COLS)
                     && aliveMask_q[hitIdx];
        rightEdge  = 11'(fleetX_q) + 11'(rcol) * 11'(SPACING_X) + 11'(ALIEN_W - 1 + STEP_X);
        leftEdge   = 11'(fleetX_q) + 11'(lcol) * 11'(SPACING_X);
        descend    = dirRight_q ? (rightEdge > 11'(X_MAX)) : (leftEdge < 11'(X_MIN + STEP_X));
        yAfter     = descend ? (fleetY_q + 10'(STEP_Y)) : fleetY_q;
        bottomNext = 11'(yAfter) + 11'(brow) * 11'(SPACING_Y) + 11'(ALIEN_H - 1);
    end

    // Next-state logic. start wins over everything; otherwise only RUN moves.
    // A hit and a step in the same cycle both land: the step was judged on the
    // pre-hit mask above, while the cleared bit feeds the next period. Clearing
    // the last invader is checked last so it overrides a same-cycle landing.
    always_comb begin
        state_d     = state_q;
        fleetX_d    = fleetX_q;
        fleetY_d    = fleetY_q;
        dirRight_d  = dirRight_q;
        aliveMask_d = aliveMask_q;
        animFrame_d = animFrame_q;
        frameCnt_d  = frameCnt_q;
        hitAck_d    = 1'b0;
        fleetStep_d = 1'b0;

        if (start) begin
            state_d     = RUN;
            fleetX_d    = 10'(START_X);
            fleetY_d    = 10'(START_Y);
            dirRight_d  = 1'b1;
            aliveMask_d = '1;
            animFrame_d = 1'b0;
            frameCnt_d  = '0;
        end else if (state_q == RUN) begin
            if (hitOk) begin
                aliveMask_d[hitIdx] = 1'b0;
                hitAck_d            = 1'b1;
            end
            if (tick) begin
                if (frameCnt_q + 6'd1 >= period) begin
                    frameCnt_d  = '0;
                    fleetStep_d = 1'b1;
                    animFrame_d = ~animFrame_q;
                    if (descend) begin
                        fleetY_d   = yAfter;
                        dirRight_d = ~dirRight_q;
                    end else if (dirRight_q) begin
                        fleetX_d = fleetX_q + 10'(STEP_X);
                    end else begin
                        fleetX_d = fleetX_q - 10'(STEP_X);
                    end
                    if (bottomNext >= 11'(LAND_Y)) begin
                        state_d = LANDED;
                    end
                end else begin
                    frameCnt_d = frameCnt_q + 6'd1;
                end
            end
            if (hitOk && popCount == 6'd1) begin
                state_d = CLEARED;
            end
        end
    end

    // State register; reset drops straight back to the start-of-wave values
    // and any pending tick is lost together with the synchroniser contents.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            fleetX_q    <= 10'(START_X);
            fleetY_q    <= 10'(START_Y);
            dirRight_q  <= 1'b1;
            aliveMask_q <= '1;
            animFrame_q <= 1'b0;
            frameCnt_q  <= '0;
            hitAck_q    <= 1'b0;
            fleetStep_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fleetX_q    <= fleetX_d;
            fleetY_q    <= fleetY_d;
            dirRight_q  <= dirRight_d;
            aliveMask_q <= aliveMask_d;
            animFrame_q <= animFrame_d;
            frameCnt_q  <= frameCnt_d;
            hitAck_q    <= hitAck_d;
            fleetStep_q <= fleetStep_d;
        end
    end

    assign hit_ack       = hitAck_q;
    assign fleet_x       = fleetX_q;
    assign fleet_y       = fleetY_q;
    assign alive_mask    = aliveMask_q;
    assign alive_count   = popCount;
    assign dir_right     = dirRight_q;
    assign anim_frame    = animFrame_q;
    assign fleet_step    = fleetStep_q;
    assign fleet_cleared = (state_q == CLEARED);
    assign fleet_landed  = (state_q == LANDED);
    assign running       = (state_q == RUN);

endmodule

// File: tb/tb_invader_fleet_ctrl.sv
// tb_invader_fleet_ctrl
// Directed bench for invader_fleet_ctrl. Instance dutA uses the default
// playfield; dutLand lowers the invasion line to 150 so a landing happens
// within a short run. Both share all inputs.
module tb_invader_fleet_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_vs = 1'b0;
    logic        start = 1'b0;
    logic        hit_valid = 1'b0;
    logic [2:0]  hit_row = '0;
    logic [2:0]  hit_col = '0;

    logic        ackA, dirA, animA, stepA, clearedA, landedA, runningA;
    logic [9:0]  xA, yA;
    logic [39:0] maskA;
    logic [5:0]  countA;

    logic        ackB, dirB, animB, stepB, clearedB, landedB, runningB;
    logic [9:0]  xB, yB;
    logic [39:0] maskB;
    logic [5:0]  countB;

    int checks = 0;
    int errors = 0;
    int stepCountA = 0;
    int stepBase;

    localparam logic [39:0] FULL_MASK = 40'hFF_FFFF_FFFF;

    always #5 Clk = ~Clk;

    // Count fleet_step pulses of dutA, sampled mid-cycle.
    always @(negedge Clk) begin
        if (stepA === 1'b1) stepCountA++;
    end

    invader_fleet_ctrl dutA (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .start(start),
        .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
        .hit_ack(ackA), .fleet_x(xA), .fleet_y(yA), .alive_mask(maskA),
        .alive_count(countA), .dir_right(dirA), .anim_frame(animA),
        .fleet_step(stepA), .fleet_cleared(clearedA), .fleet_landed(landedA),
        .running(runningA)
    );

    invader_fleet_ctrl #(.LAND_Y(150)) dutLand (
        .Clk(Clk), .Reset_n(Reset_n), .frame_vs(frame_vs), .start(start),
        .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
        .hit_ack(ackB), .fleet_x(xB), .fleet_y(yB), .alive_mask(maskB),
        .alive_count(countB), .dir_right(dirB), .anim_frame(animB),
        .fleet_step(stepB), .fleet_cleared(clearedB), .fleet_landed(landedB),
        .running(runningB)
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle collision report, then sample one cycle later.
    task automatic applyStimulus(input logic valid, input logic [2:0] row, input logic [2:0] col);
        hit_valid = valid;
        hit_row   = row;
        hit_col   = col;
        @(posedge Clk); #1;
        hit_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    // n vsync pulses, 6 clocks each; a resulting step has completed on return.
    task automatic pulseFrames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_vs = 1'b1;
            repeat (2) @(posedge Clk);
            #1;
            frame_vs = 1'b0;
            repeat (4) @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        $display("[TB] start");

        // ---------------- reset ----------------
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_x", xA, 10'd64);
        checkOutput("rst_y", yA, 10'd48);
        checkOutput("rst_count", countA, 6'd40);
        checkOutput("rst_mask", maskA, FULL_MASK);
        checkOutput("rst_dir", dirA, 1'b1);
        checkOutput("rst_anim", animA, 1'b0);
        checkOutput("rst_running", runningA, 1'b0);
        checkOutput("rst_ack", ackA, 1'b0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        stepBase = stepCountA;
        pulseFrames(3);
        checkOutput("idle_no_step", stepCountA - stepBase, 0);
        checkOutput("idle_x", xA, 10'd64);
        checkOutput("idle_running", runningA, 1'b0);

        // ---------------- pacing: 40 alive -> 11 frames ----------------
        pulseStart();
        checkOutput("start_running", runningA, 1'b1);
        stepBase = stepCountA;
        pulseFrames(10);
        checkOutput("pace_no_step_10", stepCountA - stepBase, 0);
        checkOutput("pace_x_10", xA, 10'd64);
        pulseFrames(1);
        checkOutput("pace_step_11", stepCountA - stepBase, 1);
        checkOutput("pace_x_11", xA, 10'd68);
        checkOutput("pace_anim_11", animA, 1'b1);

        // ---------------- hits ----------------
        applyStimulus(1'b1, 3'd2, 3'd3);
        checkOutput("hit23_ack", ackA, 1'b1);
        checkOutput("hit23_bit19", maskA[19], 1'b0);
        checkOutput("hit23_count", countA, 6'd39);
        applyStimulus(1'b1, 3'd2, 3'd3);
        checkOutput("rehit23_ack", ackA, 1'b0);
        checkOutput("rehit23_count", countA, 6'd39);
        applyStimulus(1'b1, 3'd6, 3'd0);
        checkOutput("row6_ack", ackA, 1'b0);
        checkOutput("row6_count", countA, 6'd39);

        // 39 alive -> period 10; nine frames, then a tenth with a hit on the tick
        stepBase = stepCountA;
        pulseFrames(9);
        checkOutput("p39_no_step_9", stepCountA - stepBase, 0);
        frame_vs = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        frame_vs = 1'b0;
        @(posedge Clk); #1;
        hit_valid = 1'b1;
        hit_row   = 3'd0;
        hit_col   = 3'd0;
        @(posedge Clk); #1;
        hit_valid = 1'b0;
        checkOutput("coinc_step", stepA, 1'b1);
        checkOutput("coinc_ack", ackA, 1'b1);
        checkOutput("coinc_x", xA, 10'd72);
        checkOutput("coinc_count", countA, 6'd38);
        checkOutput("coinc_mask", maskA, 40'hFF_FFF7_FFFE);
        checkOutput("coinc_anim", animA, 1'b0);
        repeat (2) @(posedge Clk);
        #1;

        // ---------------- edge reversal, full fleet ----------------
        pulseStart();
        pulseFrames(98 * 11);
        checkOutput("edge_x_456", xA, 10'd456);
        checkOutput("edge_y_48", yA, 10'd48);
        checkOutput("edge_dir_r", dirA, 1'b1);
        pulseFrames(11);
        checkOutput("desc_x", xA, 10'd456);
        checkOutput("desc_y", yA, 10'd56);
        checkOutput("desc_dir", dirA, 1'b0);
        checkOutput("desc_anim", animA, 1'b1);
        checkOutput("desc_landB", landedB, 1'b1);
        checkOutput("desc_landA", landedA, 1'b0);
        pulseFrames(11);
        checkOutput("left_x", xA, 10'd452);
        checkOutput("left_y", yA, 10'd56);

        // ---------------- clear the wave ----------------
        pulseStart();
        for (int i = 0; i < 39; i++) begin
            applyStimulus(1'b1, 3'(i / 8), 3'(i % 8));
        end
        checkOutput("clr_count_1", countA, 6'd1);
        checkOutput("clr_not_yet", clearedA, 1'b0);
        applyStimulus(1'b1, 3'd4, 3'd7);
        checkOutput("clr_ack", ackA, 1'b1);
        checkOutput("clr_flag", clearedA, 1'b1);
        checkOutput("clr_count_0", countA, 6'd0);
        checkOutput("clr_running", runningA, 1'b0);
        stepBase = stepCountA;
        pulseFrames(3);
        checkOutput("clr_no_step", stepCountA - stepBase, 0);
        checkOutput("clr_x_frozen", xA, 10'd64);
        pulseStart();
        checkOutput("restart_running", runningA, 1'b1);
        checkOutput("restart_mask", maskA, FULL_MASK);
        checkOutput("restart_cleared", clearedA, 1'b0);

        // ---------------- landing: only row 4 alive, period 3 ----------------
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 3'(i / 8), 3'(i % 8));
        end
        checkOutput("land_count", countB, 6'd8);
        checkOutput("land_mask", maskB, 40'hFF_0000_0000);
        pulseFrames(98 * 3);
        checkOutput("land_pre_x", xB, 10'd456);
        checkOutput("land_pre_y", yB, 10'd48);
        checkOutput("land_pre_flag", landedB, 1'b0);
        pulseFrames(3);
        checkOutput("land_y", yB, 10'd56);
        checkOutput("land_flag", landedB, 1'b1);
        checkOutput("land_running", runningB, 1'b0);
        checkOutput("land_A_running", runningA, 1'b1);
        pulseFrames(6);
        checkOutput("land_frozen_x", xB, 10'd456);
        checkOutput("land_frozen_y", yB, 10'd56);
        checkOutput("land_A_x", xA, 10'd448);
        checkOutput("land_A_anim", animA, 1'b1);

        // ---------------- reset mid-run with a tick in flight ----------------
        frame_vs = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_x", xA, 10'd64);
        checkOutput("mid_rst_y", yA, 10'd48);
        checkOutput("mid_rst_count", countA, 6'd40);
        checkOutput("mid_rst_dir", dirA, 1'b1);
        checkOutput("mid_rst_anim", animA, 1'b0);
        checkOutput("mid_rst_running", runningA, 1'b0);
        checkOutput("mid_rst_landB", landedB, 1'b0);
        frame_vs = 1'b0;
        stepBase = stepCountA;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        checkOutput("mid_rst_no_step", stepCountA - stepBase, 0);
        checkOutput("mid_rst_idle", runningA, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
